// File: rtl/ej32_fetch.sv
// Instruction fetch/sequencer: owns p, latches opcode into code, runs the phase counter.
// Latency: p/code/phase registered (1 cycle); ex_en and fetch decoded combinationally from state and stall.
// Backpressure: stall freezes p/code/phase and drops ex_en; a stalled LOAD detours through WAIT to re-read.
module ej32_fetch #(
    parameter int          ASZ = 17,
    parameter logic [7:0]  NOP = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     ram_d,
    input  logic           br_psel,
    input  logic [ASZ-1:0] br_p,
    input  logic           opnd,
    input  logic           last,
    input  logic           stall,
    output logic [ASZ-1:0] p,
    output logic [7:0]     code,
    output logic [2:0]     phase,
    output logic           ex_en,
    output logic           fetch
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        LOAD = 2'd1,
        EXEC = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [ASZ-1:0] P_ONE = {{(ASZ-1){1'b0}}, 1'b1};

    state_t         state, state_nxt;
    logic [ASZ-1:0] p_nxt;
    logic [ASZ-1:0] p_inc;
    logic [7:0]     code_nxt;
    logic [2:0]     phase_nxt;
    logic [2:0]     phase_inc;

    assign p_inc     = p + P_ONE;
    assign phase_inc = (phase == 3'd7) ? phase : phase + 3'd1;

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        code_nxt  = code;
        phase_nxt = phase;
        ex_en     = 1'b0;
        fetch     = 1'b0;
        if (stall) begin
            // The opcode byte seen during a stalled LOAD is untrustworthy; re-read it via WAIT.
            if (state == LOAD)
                state_nxt = WAIT;
        end else begin
            unique case (state)
                BOOT: state_nxt = LOAD;
                LOAD: begin
                    fetch     = 1'b1;
                    code_nxt  = ram_d;
                    phase_nxt = 3'd0;
                    p_nxt     = p_inc;
                    state_nxt = EXEC;
                end
                EXEC: begin
                    ex_en = 1'b1;
                    if (br_psel) begin
                        // Target byte needs a full read cycle before LOAD can latch it.
                        p_nxt     = br_p;
                        state_nxt = WAIT;
                    end else if (last) begin
                        if (opnd) begin
                            p_nxt     = p_inc;
                            state_nxt = WAIT;
                        end else begin
                            state_nxt = LOAD;
                        end
                    end else begin
                        phase_nxt = phase_inc;
                        if (opnd)
                            p_nxt = p_inc;
                    end
                end
                WAIT: state_nxt = LOAD;
                default: state_nxt = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
            p     <= '0;
            code  <= NOP;
            phase <= 3'd0;
        end else begin
            state <= state_nxt;
            p     <= p_nxt;
            code  <= code_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: tb/tb_ej32_fetch.sv
// Bench for ej32_fetch: directed scenarios with literal expectations, then randomized traffic,
// every cycle checked against a behavioural sequencing model driven by the same memory image.
module tb_ej32_fetch;

    localparam int ASZ   = 17;
    localparam int PMOD  = 1 << ASZ;
    localparam int MB = 0, ML = 1, ME = 2, MW = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     ram_d = 8'h00;
    logic           br_psel = 1'b0;
    logic [ASZ-1:0] br_p = '0;
    logic           opnd = 1'b0;
    logic           last = 1'b0;
    logic           stall = 1'b0;
    logic [ASZ-1:0] p;
    logic [7:0]     code;
    logic [2:0]     phase;
    logic           ex_en;
    logic           fetch;

    logic [7:0] mem [0:PMOD-1];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    int       m_mode;
    int       m_p;
    logic [7:0] m_code;
    int       m_phase;
    logic [7:0] m_rd;

    ej32_fetch #(.ASZ(ASZ), .NOP(8'h00)) dut (
        .clk(clk), .rst(rst), .ram_d(ram_d), .br_psel(br_psel), .br_p(br_p),
        .opnd(opnd), .last(last), .stall(stall),
        .p(p), .code(code), .phase(phase), .ex_en(ex_en), .fetch(fetch)
    );

    always #5 clk = ~clk;

    // Synchronous-read program memory, one cycle of latency.
    always @(posedge clk) ram_d <= mem[p];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("p",     32'(p),     32'(m_p));
        chk("code",  32'(code),  32'(m_code));
        chk("phase", 32'(phase), 32'(m_phase));
        chk("ex_en", 32'(ex_en), 32'((m_mode == ME) && !stall));
        chk("fetch", 32'(fetch), 32'((m_mode == ML) && !stall));
    endtask

    task automatic model_step();
        logic [7:0] rd_next;
        rd_next = mem[m_p];
        if (rst) begin
            m_mode = MB; m_p = 0; m_code = 8'h00; m_phase = 0;
        end else if (stall) begin
            if (m_mode == ML) m_mode = MW;
        end else begin
            case (m_mode)
                MB: m_mode = ML;
                ML: begin
                    m_code = m_rd; m_phase = 0; m_p = (m_p + 1) % PMOD; m_mode = ME;
                end
                ME: begin
                    if (br_psel) begin
                        m_p = int'(br_p); m_mode = MW;
                    end else if (last) begin
                        if (opnd) begin m_p = (m_p + 1) % PMOD; m_mode = MW; end
                        else m_mode = ML;
                    end else begin
                        m_phase = (m_phase < 7) ? m_phase + 1 : 7;
                        if (opnd) m_p = (m_p + 1) % PMOD;
                    end
                end
                default: m_mode = ML;
            endcase
        end
        m_rd = rd_next;
    endtask

    // One clock: compare mid-cycle, advance the model on the edge, return just after it.
    task automatic tick();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_in(input logic b, input logic [ASZ-1:0] bp, input logic o, input logic l,
                          input logic s);
        br_psel = b; br_p = bp; opnd = o; last = l; stall = s;
    endtask

    initial begin
        m_mode = MB; m_p = 0; m_code = 8'h00; m_phase = 0; m_rd = 8'h00;
        for (int i = 0; i < PMOD; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h11; mem[2] = 8'h12;
        mem[17'h20] = 8'hA7; mem[17'h40] = 8'h5C; mem[17'h31] = 8'h3E;
        mem[17'h50] = 8'hC4;

        // Reset
        rst = 1'b1;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        chk("rst_p", 32'(p), 32'h0);
        chk("rst_code", 32'(code), 32'h00);
        rst = 1'b0;
        tick();
        chk("boot_fetch", 32'(fetch), 32'h1);
        set_in(0, '0, 0, 1, 0);
        tick();
        chk("first_code", 32'(code), 32'h10);
        chk("first_p", 32'(p), 32'h1);
        chk("first_ex_en", 32'(ex_en), 32'h1);

        // Three one-byte instructions
        tick(); chk("seq_p1", 32'(p), 32'h1); chk("seq_fetch1", 32'(fetch), 32'h1);
        tick(); chk("seq_p2", 32'(p), 32'h2); chk("seq_code2", 32'(code), 32'h11);
        tick(); chk("seq_p3", 32'(p), 32'h2);
        tick(); chk("seq_p4", 32'(p), 32'h3); chk("seq_phase", 32'(phase), 32'h0);

        // Goto at 0x20
        set_in(1, 17'h20, 0, 0, 0); tick();
        set_in(0, '0, 0, 0, 0); tick(); tick();
        chk("goto_code", 32'(code), 32'hA7);
        set_in(0, '0, 1, 0, 0); tick();
        chk("goto_opnd_p", 32'(p), 32'h22); chk("goto_phase", 32'(phase), 32'h1);
        set_in(1, 17'h40, 0, 0, 0); tick();
        chk("br_wait_ex_en", 32'(ex_en), 32'h0); chk("br_wait_p", 32'(p), 32'h40);
        set_in(0, '0, 0, 0, 0); tick();
        chk("br_load_fetch", 32'(fetch), 32'h1);
        tick();
        chk("br_code", 32'(code), 32'h5C); chk("br_p_after", 32'(p), 32'h41);

        // opnd and last together at 0x30
        set_in(1, 17'h2F, 0, 0, 0); tick();
        set_in(0, '0, 0, 0, 0); tick(); tick();
        chk("ol_start_p", 32'(p), 32'h30);
        set_in(0, '0, 1, 1, 0); tick();
        chk("ol_p", 32'(p), 32'h31); chk("ol_wait_ex_en", 32'(ex_en), 32'h0);
        set_in(0, '0, 0, 0, 0); tick(); tick();
        chk("ol_code", 32'(code), 32'h3E);

        // Stall during LOAD at 0x50
        set_in(1, 17'h50, 0, 0, 0); tick();
        set_in(0, '0, 0, 0, 0); tick();
        chk("st_load_fetch", 32'(fetch), 32'h1);
        set_in(0, '0, 1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            chk("st_ex_en", 32'(ex_en), 32'h0);
            tick();
            chk("st_p", 32'(p), 32'h50); chk("st_code", 32'(code), 32'h3E);
        end
        set_in(0, '0, 0, 0, 0); tick();
        chk("st_reload_fetch", 32'(fetch), 32'h1);
        tick();
        chk("st_code_after", 32'(code), 32'hC4); chk("st_p_after", 32'(p), 32'h51);

        // Phase saturation
        set_in(0, '0, 0, 0, 0);
        for (int k = 0; k < 9; k++) tick();
        chk("phase_sat", 32'(phase), 32'h7);

        // Wrap
        set_in(1, 17'h1FFFF, 0, 0, 0); tick();
        set_in(0, '0, 0, 0, 0); tick(); tick();
        chk("wrap_p", 32'(p), 32'h0);
        set_in(0, '0, 1, 0, 0); tick();
        // Reset mid-instruction under stall
        rst = 1'b1; set_in(0, '0, 1, 0, 1); tick();
        chk("mid_rst_p", 32'(p), 32'h0); chk("mid_rst_code", 32'(code), 32'h00);
        chk("mid_rst_phase", 32'(phase), 32'h0);
        chk("mid_rst_ex_en", 32'(ex_en), 32'h0); chk("mid_rst_fetch", 32'(fetch), 32'h0);
        rst = 1'b0; set_in(0, '0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 199) == 0);
            stall   = ($urandom_range(0, 7) == 0);
            br_psel = ($urandom_range(0, 5) == 0);
            br_p    = ASZ'($urandom);
            opnd    = ($urandom_range(0, 2) == 0);
            last    = ($urandom_range(0, (i < 2000) ? 2 : 11) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
